// File: rtl/mem_block_loader_pkg.sv
// Shared width constants and FSM state encoding for the memory block loader.
// The RD state only exists when MEM_LOADER_VERIFY_EN is defined.
package mem_block_loader_pkg;

  localparam int DATA_INDEX_LIMIT    = 31;
  localparam int ADDRESS_INDEX_LIMIT = 25;

  typedef enum logic [2:0] {
    MLD_IDLE = 3'd0,
    MLD_FILL = 3'd1,
    MLD_WR   = 3'd2,
`ifdef MEM_LOADER_VERIFY_EN
    MLD_RD   = 3'd3,
`endif
    MLD_FIN  = 3'd4
  } mld_state_t;

endpackage

// File: rtl/mem_block_loader_ctrl.sv
// Loader sequencer: FSM with registered bus/handshake outputs plus the
// cur_addr and remaining counters. MEM_LOADER_VERIFY_EN adds the RD phase.
module mem_loader_ctrl
  import mem_block_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDRESS_INDEX_LIMIT + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] addr
`ifdef MEM_LOADER_VERIFY_EN
  ,
  output logic                  start_ok
`endif
);

  mld_state_t            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  last;

  // The advance step runs when leaving the final bus phase of each word.
`ifdef MEM_LOADER_VERIFY_EN
  localparam mld_state_t LAST_PHASE = MLD_RD;
  assign start_ok = (state == MLD_IDLE) && start;
`else
  localparam mld_state_t LAST_PHASE = MLD_WR;
  assign read = 1'b0;
`endif

  assign last = (remaining == ADDR_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MLD_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
`ifdef MEM_LOADER_VERIFY_EN
      read      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        MLD_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= word_count;
            if (word_count == '0) begin
              state <= MLD_FIN;
              done  <= 1'b1;
            end else begin
              state    <= MLD_FILL;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        MLD_FILL: begin
          if (in_valid) begin
            state    <= MLD_WR;
            in_ready <= 1'b0;
            write    <= 1'b1;
            addr     <= cur_addr;
          end
        end
        MLD_WR: begin
          write <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
          state <= MLD_RD;
          read  <= 1'b1;
`endif
        end
`ifdef MEM_LOADER_VERIFY_EN
        MLD_RD: read <= 1'b0;
`endif
        MLD_FIN: state <= MLD_IDLE;
        default: state <= MLD_IDLE;
      endcase

      if (state == LAST_PHASE) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
        if (last) begin
          state <= MLD_FIN;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state    <= MLD_FILL;
          in_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_block_loader.sv
// Streams words into consecutive memory addresses over the shared memory bus.
// Define MEM_LOADER_VERIFY_EN to read back each word and flag mismatches on ERROR.
module mem_block_loader
  import mem_block_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_INDEX_LIMIT + 1,
  parameter int ADDR_WIDTH = ADDRESS_INDEX_LIMIT + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH-1:0] WORD_COUNT,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_WIDTH-1:0] ADDR,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  output logic                  READ,
  output logic                  WRITE
);

  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  data_oe;
  logic                  accept;
`ifdef MEM_LOADER_VERIFY_EN
  logic                  start_ok;
`endif

  assign accept = IN_READY & IN_VALID;

  mem_loader_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .clk        (CLK),
    .rst        (RST),
    .start      (START),
    .base_addr  (BASE_ADDR),
    .word_count (WORD_COUNT),
    .in_valid   (IN_VALID),
    .in_ready   (IN_READY),
    .busy       (BUSY),
    .done       (DONE),
    .write      (WRITE),
    .read       (READ),
    .addr       (ADDR)
`ifdef MEM_LOADER_VERIFY_EN
    ,
    .start_ok   (start_ok)
`endif
  );

  // An accepted word always leads to exactly one WR cycle, so the drive
  // enable flop is loaded on the same condition as WRITE and tracks it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_reg <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_oe <= accept;
      if (accept) hold_reg <= IN_DATA;
    end
  end

  assign DATA = data_oe ? hold_reg : 'z;

`ifdef MEM_LOADER_VERIFY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ERROR <= 1'b0;
    else if (start_ok)
      ERROR <= 1'b0;
    else if (READ && (DATA != hold_reg))
      ERROR <= 1'b1;
  end
`else
  assign ERROR = 1'b0;
`endif

endmodule
